axil_mem_arbiter: RTL and testbench



---
 rtl/axil_mem_pkg.sv | 19 +
 rtl/axil_mem_arbiter_if.sv | 37 +++
 rtl/axil_addr_check.sv | 22 ++
 rtl/axil_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_axil_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_mem_pkg.sv
// Shared types for the AXI-Lite to single-port memory arbiter.
package axil_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_RESP,
    ST_WR_RESP
  } state_e;

  typedef enum logic {
    GRANT_READ,
    GRANT_WRITE
  } grant_e;

endpackage

// File: rtl/axil_mem_arbiter_if.sv
// AXI-Lite read/write channel bundle between the converter and the memory arbiter.
interface axil_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   aw_addr_i;
  logic                    aw_valid_i;
  logic                    aw_ready_o;
  logic [DATA_WIDTH-1:0]   w_data_i;
  logic [DATA_WIDTH/8-1:0] w_strb_i;
  logic                    w_valid_i;
  logic                    w_ready_o;
  logic [1:0]              b_resp_o;
  logic                    b_valid_o;
  logic                    b_ready_i;
  logic [ADDR_WIDTH-1:0]   ar_addr_i;
  logic                    ar_valid_i;
  logic                    ar_ready_o;
  logic [DATA_WIDTH-1:0]   r_data_o;
  logic [1:0]              r_resp_o;
  logic                    r_valid_o;
  logic                    r_ready_i;

  modport master (
    output aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
           ar_addr_i, ar_valid_i, r_ready_i,
    input  aw_ready_o, w_ready_o, b_resp_o, b_valid_o, ar_ready_o,
           r_data_o, r_resp_o, r_valid_o
  );

  modport slave (
    input  aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
           ar_addr_i, ar_valid_i, r_ready_i,
    output aw_ready_o, w_ready_o, b_resp_o, b_valid_o, ar_ready_o,
           r_data_o, r_resp_o, r_valid_o
  );
endinterface

// File: rtl/axil_addr_check.sv
// Memory window check and byte-to-word address conversion for one AXI-Lite channel.
module axil_addr_check #(
  parameter logic [63:0] MEM_BASE   = 64'h1000,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MEM_AW     = 12
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  in_range_c,
  output logic [MEM_AW-1:0]     word_addr_c
);
  localparam int unsigned OFF_LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned CMP_W   = 66;
  localparam logic [CMP_W-1:0] WIN_BYTES = CMP_W'(1) << (MEM_AW + OFF_LSB);

  logic [ADDR_WIDTH-1:0] offset;

  // Offset wraps at ADDR_WIDTH; the explicit lower-bound test rejects wrapped addresses.
  assign offset      = addr_i - ADDR_WIDTH'(MEM_BASE);
  assign in_range_c  = (CMP_W'(addr_i) >= CMP_W'(MEM_BASE)) && (CMP_W'(offset) < WIN_BYTES);
  assign word_addr_c = MEM_AW'(offset >> OFF_LSB);
endmodule

// File: rtl/axil_mem_arbiter.sv
// One-outstanding-transaction scheduler between AXI-Lite and a 1-cycle-latency
// single-port memory, with read/write round-robin and window checking.
module axil_mem_arbiter
  import axil_mem_pkg::*;
#(
  parameter logic [63:0] MEM_BASE   = 64'h1000,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MEM_AW     = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  axil_mem_arbiter_if.slave       bus,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [MEM_AW-1:0]       mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  localparam int unsigned BE_W = DATA_WIDTH / 8;

  state_e                state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic                  bubble_q, bubble_d;
  logic                  rd_ok_q, rd_ok_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic                  b_valid_q, b_valid_d;
  logic [1:0]            b_resp_q, b_resp_d;

  logic              ar_in_range, aw_in_range;
  logic [MEM_AW-1:0] ar_word, aw_word;
  logic              wr_pend, can_grant, grant_rd, grant_wr;

  axil_addr_check #(
    .MEM_BASE(MEM_BASE), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_AW(MEM_AW)
  ) u_ar_chk (
    .addr_i(bus.ar_addr_i), .in_range_c(ar_in_range), .word_addr_c(ar_word)
  );

  axil_addr_check #(
    .MEM_BASE(MEM_BASE), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_AW(MEM_AW)
  ) u_aw_chk (
    .addr_i(bus.aw_addr_i), .in_range_c(aw_in_range), .word_addr_c(aw_word)
  );

  // Grant decision: only in IDLE after the post-response bubble; ties go opposite of last grant.
  always_comb begin
    wr_pend   = bus.aw_valid_i & bus.w_valid_i;
    can_grant = (state_q == ST_IDLE) & ~bubble_q & ~rst_i;
    grant_rd  = can_grant & bus.ar_valid_i & (~wr_pend | (last_grant_q == GRANT_WRITE));
    grant_wr  = can_grant & wr_pend & (~bus.ar_valid_i | (last_grant_q == GRANT_READ));
  end

  assign bus.ar_ready_o = grant_rd;
  assign bus.aw_ready_o = grant_wr;
  assign bus.w_ready_o  = grant_wr;

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (grant_wr && aw_in_range) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = aw_word;
      mem_be_o    = BE_W'(bus.w_strb_i);
      mem_wdata_o = bus.w_data_i;
    end else if (grant_rd && ar_in_range) begin
      mem_en_o   = 1'b1;
      mem_addr_o = ar_word;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    bubble_d     = 1'b0;
    rd_ok_d      = rd_ok_q;
    r_valid_d    = r_valid_q;
    r_data_d     = r_data_q;
    r_resp_d     = r_resp_q;
    b_valid_d    = b_valid_q;
    b_resp_d     = b_resp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_rd) begin
          last_grant_d = GRANT_READ;
          rd_ok_d      = ar_in_range;
          state_d      = ST_RD_WAIT;
        end else if (grant_wr) begin
          last_grant_d = GRANT_WRITE;
          b_resp_d     = aw_in_range ? RESP_OKAY : RESP_SLVERR;
          b_valid_d    = 1'b1;
          state_d      = ST_WR_RESP;
        end
      end
      // Out-of-range reads still pass through here so both outcomes share one latency.
      ST_RD_WAIT: begin
        r_data_d  = rd_ok_q ? mem_rdata_i : '0;
        r_resp_d  = rd_ok_q ? RESP_OKAY : RESP_SLVERR;
        r_valid_d = 1'b1;
        state_d   = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (bus.r_ready_i) begin
          r_valid_d = 1'b0;
          bubble_d  = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WR_RESP: begin
        if (bus.b_ready_i) begin
          b_valid_d = 1'b0;
          bubble_d  = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_WRITE;
      bubble_q     <= 1'b0;
      rd_ok_q      <= 1'b0;
      r_valid_q    <= 1'b0;
      r_data_q     <= '0;
      r_resp_q     <= RESP_OKAY;
      b_valid_q    <= 1'b0;
      b_resp_q     <= RESP_OKAY;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      bubble_q     <= bubble_d;
      rd_ok_q      <= rd_ok_d;
      r_valid_q    <= r_valid_d;
      r_data_q     <= r_data_d;
      r_resp_q     <= r_resp_d;
      b_valid_q    <= b_valid_d;
      b_resp_q     <= b_resp_d;
    end
  end

  assign bus.r_valid_o = r_valid_q;
  assign bus.r_data_o  = r_data_q;
  assign bus.r_resp_o  = r_resp_q;
  assign bus.b_valid_o = b_valid_q;
  assign bus.b_resp_o  = b_resp_q;
endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Scoreboard bench for axil_mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level memory/arbitration model.
module tb_axil_mem_arbiter;
  import axil_mem_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 64;
  localparam int unsigned MAW   = 12;
  localparam int unsigned BEW   = DW / 8;
  localparam int          WORDS = 4096;
  localparam logic [63:0] BASE  = 64'h1000;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    int          due;
  } rexp_t;

  typedef struct {
    logic [1:0] resp;
    int         due;
  } bexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic           mem_en, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [BEW-1:0] mem_be;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata = '0;

  axil_mem_arbiter #(
    .MEM_BASE(BASE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(MAW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Block memory with one cycle read latency, cleared on the first clock.
  logic [DW-1:0] mem [WORDS];
  bit            mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      mem_init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < int'(BEW); b++)
          if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          en_cnt   = 0;
  logic [63:0] ref_mem [int];
  rexp_t       rq [$];
  bexp_t       bq [$];
  bit          glog [$];
  bit          outstanding = 1'b0, last_wr = 1'b1, prev_en = 1'b0, post_rst = 1'b0;
  bit          r_seen = 1'b0, b_seen = 1'b0;
  bit          ar_hs_seen = 1'b0, wr_hs_seen = 1'b0;
  bit          rr_hold = 1'b0, rnd_bp = 1'b0;
  logic [63:0] last_rdata = '0;
  logic [1:0]  last_rresp = '0, last_bresp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit in_rng(input logic [AW-1:0] a);
    longint unsigned x = 64'(a);
    return (x >= BASE) && (x < BASE + 64'(WORDS) * 64'(BEW));
  endfunction

  function automatic int word_idx(input logic [AW-1:0] a);
    return int'((64'(a) - BASE) / 64'(BEW));
  endfunction

  function automatic logic [63:0] ref_rd(input int i);
    return ref_mem.exists(i) ? ref_mem[i] : 64'd0;
  endfunction

  // Monitor: sampled on the falling edge, describes what the next rising edge will commit.
  always @(negedge clk) begin
    logic        g_rd, g_wr, rd_pend, wr_pend, exp_rd, exp_en, busy;
    logic [63:0] w;
    int          idx;
    if (rst) begin
      check("reset_quiet", 64'({bus.ar_ready_o, bus.aw_ready_o, bus.w_ready_o, mem_en}), 64'd0);
      rq.delete(); bq.delete();
      outstanding = 1'b0; last_wr = 1'b1; prev_en = 1'b0; post_rst = 1'b1;
      r_seen = 1'b0; b_seen = 1'b0; ar_hs_seen = 1'b0; wr_hs_seen = 1'b0;
    end else begin
      if (post_rst) begin
        check("post_reset_valids", 64'({bus.r_valid_o, bus.b_valid_o}), 64'd0);
        post_rst = 1'b0;
      end
      busy = outstanding;
      if (bus.r_valid_o) begin
        if (rq.size() == 0) check("r_unexpected_valid", 64'(bus.r_valid_o), 64'd0);
        else begin
          if (!r_seen) check("r_latency", 64'(cyc), 64'(rq[0].due));
          r_seen = 1'b1;
          check("r_data", bus.r_data_o, rq[0].data);
          check("r_resp", 64'(bus.r_resp_o), 64'(rq[0].resp));
          if (bus.r_ready_i) begin
            last_rdata = bus.r_data_o; last_rresp = bus.r_resp_o;
            void'(rq.pop_front()); r_seen = 1'b0; outstanding = 1'b0;
          end
        end
      end else if (rq.size() > 0 && (r_seen || cyc > rq[0].due)) begin
        check("r_valid_held", 64'(bus.r_valid_o), 64'd1);
        void'(rq.pop_front()); r_seen = 1'b0; outstanding = 1'b0;
      end
      if (bus.b_valid_o) begin
        if (bq.size() == 0) check("b_unexpected_valid", 64'(bus.b_valid_o), 64'd0);
        else begin
          if (!b_seen) check("b_latency", 64'(cyc), 64'(bq[0].due));
          b_seen = 1'b1;
          check("b_resp", 64'(bus.b_resp_o), 64'(bq[0].resp));
          if (bus.b_ready_i) begin
            last_bresp = bus.b_resp_o;
            void'(bq.pop_front()); b_seen = 1'b0; outstanding = 1'b0;
          end
        end
      end else if (bq.size() > 0 && (b_seen || cyc > bq[0].due)) begin
        check("b_valid_held", 64'(bus.b_valid_o), 64'd1);
        void'(bq.pop_front()); b_seen = 1'b0; outstanding = 1'b0;
      end

      rd_pend = bus.ar_valid_i;
      wr_pend = bus.aw_valid_i & bus.w_valid_i;
      g_rd    = bus.ar_valid_i & bus.ar_ready_o;
      g_wr    = wr_pend & bus.aw_ready_o & bus.w_ready_o;
      ar_hs_seen = g_rd;
      wr_hs_seen = g_wr;
      if (bus.ar_ready_o || bus.aw_ready_o || bus.w_ready_o) begin
        check("aw_w_ready_pair", 64'(bus.aw_ready_o), 64'(bus.w_ready_o));
        check("aw_ready_needs_w", 64'(bus.aw_ready_o & ~wr_pend), 64'd0);
        check("ready_while_busy", 64'(busy), 64'd0);
        exp_rd = rd_pend & (~wr_pend | last_wr);
        check("grant_sel", 64'({g_rd, g_wr}), exp_rd ? 64'd2 : 64'd1);
      end
      exp_en = (g_rd & in_rng(bus.ar_addr_i)) | (g_wr & in_rng(bus.aw_addr_i));
      if (mem_en || exp_en) begin
        check("mem_en", 64'(mem_en), 64'(exp_en));
        if (exp_en) begin
          idx = g_wr ? word_idx(bus.aw_addr_i) : word_idx(bus.ar_addr_i);
          check("mem_we", 64'(mem_we), 64'(g_wr));
          check("mem_addr", 64'(mem_addr), 64'(idx));
          if (g_wr) begin
            check("mem_be", 64'(mem_be), 64'(bus.w_strb_i));
            check("mem_wdata", mem_wdata, bus.w_data_i);
          end
        end
      end
      if (mem_en) begin
        en_cnt++;
        check("mem_en_back_to_back", 64'(prev_en), 64'd0);
      end
      prev_en = mem_en;

      if (g_rd) begin
        if (in_rng(bus.ar_addr_i))
          rq.push_back(rexp_t'{ref_rd(word_idx(bus.ar_addr_i)), RESP_OKAY, cyc + 2});
        else
          rq.push_back(rexp_t'{64'd0, RESP_SLVERR, cyc + 2});
        outstanding = 1'b1; last_wr = 1'b0; glog.push_back(1'b0);
      end else if (g_wr) begin
        if (in_rng(bus.aw_addr_i)) begin
          idx = word_idx(bus.aw_addr_i);
          w = ref_rd(idx);
          for (int b = 0; b < int'(BEW); b++)
            if (bus.w_strb_i[b]) w[b*8 +: 8] = bus.w_data_i[b*8 +: 8];
          ref_mem[idx] = w;
          bq.push_back(bexp_t'{RESP_OKAY, cyc + 1});
        end else begin
          bq.push_back(bexp_t'{RESP_SLVERR, cyc + 1});
        end
        outstanding = 1'b1; last_wr = 1'b1; glog.push_back(1'b1);
      end
    end
  end

  initial begin
    bus.r_ready_i = 1'b0;
    bus.b_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.r_ready_i = !rr_hold && (!rnd_bp || $urandom_range(0, 3) != 0);
      bus.b_ready_i = !rnd_bp || $urandom_range(0, 3) != 0;
    end
  end

  // Drives one read and/or one write until each is accepted; entered and left at posedge+1.
  task automatic txn(input bit rd, input bit wr, input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic [BEW-1:0] ws, input int aw_dly, input int w_dly);
    bit rd_done = !rd;
    bit wr_done = !wr;
    int t = 0;
    bus.ar_addr_i = ra; bus.aw_addr_i = wa; bus.w_data_i = wd; bus.w_strb_i = ws;
    while (!(rd_done && wr_done) && t < 300) begin
      bus.ar_valid_i = rd && !rd_done;
      bus.aw_valid_i = wr && !wr_done && t >= aw_dly;
      bus.w_valid_i  = wr && !wr_done && t >= w_dly;
      @(posedge clk);
      if (ar_hs_seen) rd_done = 1'b1;
      if (wr_hs_seen) wr_done = 1'b1;
      #1; t++;
    end
    bus.ar_valid_i = 1'b0; bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0;
    check("txn_accepted", 64'({rd_done, wr_done}), 64'd3);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((rq.size() != 0 || bq.size() != 0 || outstanding) && t < 300) begin
      @(posedge clk); #1; t++;
    end
    check("drain", 64'({outstanding, 8'(rq.size()), 8'(bq.size())}), 64'd0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r   = int'($urandom_range(0, 9));
    int idx = int'($urandom_range(0, 15));
    idx = (idx < 8) ? idx : WORDS - 16 + idx;
    if (r == 0) return AW'(BASE - 64'd8 * 64'($urandom_range(1, 4)));
    if (r == 1) return AW'(BASE + 64'(WORDS) * 64'(BEW) + 64'd8 * 64'($urandom_range(0, 3)));
    return AW'(BASE + 64'(idx) * 64'(BEW));
  endfunction

  initial begin
    logic [3:0] ord;
    int         en0, t;
    logic [AW-1:0] oor_wr;
    bus.ar_valid_i = 1'b0; bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0;
    bus.ar_addr_i = '0; bus.aw_addr_i = '0; bus.w_data_i = '0; bus.w_strb_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Contention straight out of reset: order must be R, W, R, W.
    txn(1, 1, 32'h1010, 32'h1018, 64'h1111_2222_3333_4444, 8'hFF, 0, 0);
    txn(1, 1, 32'h1018, 32'h1020, 64'h5555_6666_7777_8888, 8'hFF, 0, 0);
    wait_idle();
    ord = (glog.size() >= 4) ? {glog[0], glog[1], glog[2], glog[3]} : 4'hF;
    check("contention_order", 64'(ord), 64'b0101);

    txn(0, 1, '0, 32'h1008, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0);
    wait_idle();
    check("single_wr_bresp", 64'(last_bresp), 64'(RESP_OKAY));
    txn(1, 0, 32'h1008, '0, '0, '0, 0, 0);
    wait_idle();
    check("single_rd_data", last_rdata, 64'hDEADBEEF_CAFEF00D);

    en0 = en_cnt;
    oor_wr = AW'(BASE + 64'(WORDS) * 64'(BEW));
    txn(1, 0, 32'h0FF8, '0, '0, '0, 0, 0);
    wait_idle();
    check("oor_rd_resp", 64'(last_rresp), 64'(RESP_SLVERR));
    check("oor_rd_data", last_rdata, 64'd0);
    txn(0, 1, '0, oor_wr, 64'hABCD, 8'hFF, 0, 0);
    wait_idle();
    check("oor_wr_resp", 64'(last_bresp), 64'(RESP_SLVERR));
    check("oor_no_mem_en", 64'(en_cnt - en0), 64'd0);

    // Backpressure: hold r_ready low with a second read waiting.
    rr_hold = 1'b1;
    txn(1, 0, 32'h1008, '0, '0, '0, 0, 0);
    fork
      txn(1, 0, 32'h1010, '0, '0, '0, 0, 0);
      begin
        logic [63:0] d0;
        t = 0;
        while (!bus.r_valid_o && t < 20) begin @(negedge clk); t++; end
        d0 = bus.r_data_o;
        repeat (10) begin
          @(negedge clk);
          check("bp_r_valid", 64'(bus.r_valid_o), 64'd1);
          check("bp_r_data_stable", bus.r_data_o, d0);
        end
        @(posedge clk); #1 rr_hold = 1'b0;
      end
    join
    wait_idle();

    // Byte-strobed write over an all-ones word, with aw leading w by 5 cycles.
    txn(0, 1, '0, 32'h1028, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
    wait_idle();
    txn(0, 1, '0, 32'h1028, 64'd0, 8'h0F, 0, 5);
    wait_idle();
    txn(1, 0, 32'h1028, '0, '0, '0, 0, 0);
    wait_idle();
    check("partial_rd_data", last_rdata, 64'hFFFFFFFF_00000000);

    // Reset while a read response is pending.
    rr_hold = 1'b1;
    txn(1, 0, 32'h1028, '0, '0, '0, 0, 0);
    t = 0;
    while (!bus.r_valid_o && t < 20) begin @(negedge clk); t++; end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    rr_hold = 1'b0;
    glog.delete();
    txn(1, 1, 32'h1000, 32'h1030, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0);
    wait_idle();
    check("post_reset_first_grant_read", 64'((glog.size() > 0) ? glog[0] : 1'b1), 64'd0);

    rnd_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int mode = int'($urandom_range(0, 2));
      txn(mode != 1, mode != 0, rand_addr(), rand_addr(), {$urandom, $urandom},
          BEW'($urandom_range(0, 255)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_err);
    $fatal(1);
  end
endmodule
